// File: rtl/module_bin_display_mux.sv
// -----------------------------------------------------------------------------
// module_bin_display_mux
//
// Binary-to-7-segment display engine. A binary value accepted on load_i is
// converted to DIGITS BCD digits by a shift-and-add-3 (double-dabble) FSM.
// The committed result is scanned onto a common-anode display, one digit per
// DISPLAY_REFRESH clock cycles.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   bin_i       binary value, sampled only when a load is accepted
//   load_i      conversion request, accepted only while busy_o = 0
//   busy_o      conversion in progress
//   bcd_o       last committed BCD result, digit 0 (units) in bits [3:0]
//   overflow_o  last committed value did not fit in DIGITS digits
//   anodo_o     anode enables, active-low, one-hot-low
//   catodo_o    segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module module_bin_display_mux #(
   parameter int BIN_WIDTH       = 8,
   parameter int DIGITS          = 4,
   parameter int DISPLAY_REFRESH = 27000,
   parameter int BLANK_ZEROS     = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [BIN_WIDTH-1:0]   bin_i,
   input  logic                   load_i,
   output logic                   busy_o,
   output logic [4*DIGITS-1:0]    bcd_o,
   output logic                   overflow_o,
   output logic [DIGITS-1:0]      anodo_o,
   output logic [6:0]             catodo_o
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_WIDTH;
   localparam int IT_W  = $clog2(BIN_WIDTH + 1);
   localparam int REF_W = $clog2(DISPLAY_REFRESH + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Active-low segment pattern for one BCD nibble; non-decimal codes go dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
   function automatic logic [SR_W-1:0] dabble_adjust(input logic [SR_W-1:0] sr);
      logic [SR_W-1:0] adj;
      adj = sr;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
            adj[BIN_WIDTH + 4*i +: 4] = sr[BIN_WIDTH + 4*i +: 4] + 4'd3;
         end else begin
            adj[BIN_WIDTH + 4*i +: 4] = sr[BIN_WIDTH + 4*i +: 4];
         end
      end
      return adj;
   endfunction

   state_t              state_r;
   state_t              state_next_s;
   logic                load_take_s;
   logic                shift_en_s;
   logic                commit_s;

   logic [SR_W-1:0]     shift_r;
   logic [SR_W-1:0]     adj_s;
   logic [IT_W-1:0]     iter_r;
   logic                carry_r;
   logic                busy_r;
   logic [BCD_W-1:0]    bcd_r;
   logic                ovf_r;

   logic [REF_W-1:0]    ref_cnt_r;
   logic [IDX_W-1:0]    idx_r;
   logic [3:0]          nib_s;
   logic                upper_zero_s;
   logic [DIGITS-1:0]   anode_sel_s;
   logic [DIGITS-1:0]   an_next_s;
   logic [6:0]          cat_next_s;
   logic [DIGITS-1:0]   anodo_r;
   logic [6:0]          catodo_r;

   assign adj_s = dabble_adjust(shift_r);

   // Conversion FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Conversion FSM next-state and datapath control strobes.
   always_comb begin
      state_next_s = state_r;
      load_take_s  = 1'b0;
      shift_en_s   = 1'b0;
      commit_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_i) begin
               load_take_s  = 1'b1;
               state_next_s = ST_SHIFT;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_en_s = 1'b1;
            if (iter_r == IT_W'(BIN_WIDTH - 1)) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            commit_s     = 1'b1;
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Double-dabble shift register, iteration count, sticky carry and commit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_r <= {SR_W{1'b0}};
         iter_r  <= {IT_W{1'b0}};
         carry_r <= 1'b0;
         busy_r  <= 1'b0;
         bcd_r   <= {BCD_W{1'b0}};
         ovf_r   <= 1'b0;
      end else if (load_take_s) begin
         shift_r <= {{BCD_W{1'b0}}, bin_i};
         iter_r  <= {IT_W{1'b0}};
         carry_r <= 1'b0;
         busy_r  <= 1'b1;
      end else if (shift_en_s) begin
         // A one leaving the top nibble means the value exceeds DIGITS digits.
         shift_r <= {adj_s[SR_W-2:0], 1'b0};
         iter_r  <= iter_r + IT_W'(1);
         carry_r <= carry_r | adj_s[SR_W-1];
      end else if (commit_s) begin
         bcd_r  <= shift_r[SR_W-1 -: BCD_W];
         ovf_r  <= carry_r;
         busy_r <= 1'b0;
      end
   end

   // Free-running refresh counter and digit index, independent of the FSM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ref_cnt_r <= {REF_W{1'b0}};
         idx_r     <= {IDX_W{1'b0}};
      end else if (ref_cnt_r == REF_W'(DISPLAY_REFRESH - 1)) begin
         ref_cnt_r <= {REF_W{1'b0}};
         if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_r <= {IDX_W{1'b0}};
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         ref_cnt_r <= ref_cnt_r + REF_W'(1);
      end
   end

   // Digit selection with overflow dashes and leading-zero blanking.
   always_comb begin
      nib_s        = 4'(bcd_r >> {idx_r, 2'b00});
      // Digit idx and everything above it are zero.
      upper_zero_s = ((bcd_r >> {idx_r, 2'b00}) == {BCD_W{1'b0}});
      anode_sel_s  = {DIGITS{1'b1}};
      for (int i = 0; i < DIGITS; i++) begin
         anode_sel_s[i] = (idx_r != IDX_W'(i));
      end
      an_next_s  = {DIGITS{1'b1}};
      cat_next_s = 7'b1111111;
      if (ovf_r) begin
         an_next_s  = anode_sel_s;
         cat_next_s = 7'b0111111;
      end else if ((BLANK_ZEROS != 0) && (idx_r != {IDX_W{1'b0}}) && upper_zero_s) begin
         an_next_s  = {DIGITS{1'b1}};
         cat_next_s = 7'b1111111;
      end else begin
         an_next_s  = anode_sel_s;
         cat_next_s = seg_decode(nib_s);
      end
   end

   // Registered display drive.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         anodo_r  <= {DIGITS{1'b1}};
         catodo_r <= 7'b1111111;
      end else begin
         anodo_r  <= an_next_s;
         catodo_r <= cat_next_s;
      end
   end

   assign busy_o     = busy_r;
   assign bcd_o      = bcd_r;
   assign overflow_o = ovf_r;
   assign anodo_o    = anodo_r;
   assign catodo_o   = catodo_r;

endmodule
